// File: rtl/keypad_pkg.sv
// Shared types and key-code lookup for the 4x4 keypad emulator.
package keypad_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BOUNCE_IN,
        S_HOLD,
        S_BOUNCE_OUT,
        S_GAP
    } state_t;

    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
    } key_pos_t;

    localparam logic [3:0] ROW_IDLE = 4'b1111;
    localparam logic [3:0] COL_IDLE = 4'b1111;

    // Same layout the scanner decodes: r3 row is * 0 # D, with * = E and # = F.
    function automatic key_pos_t key_pos(input logic [3:0] key);
        key_pos_t p;
        case (key)
            4'h1: p = {2'd0, 2'd0};
            4'h2: p = {2'd0, 2'd1};
            4'h3: p = {2'd0, 2'd2};
            4'hA: p = {2'd0, 2'd3};
            4'h4: p = {2'd1, 2'd0};
            4'h5: p = {2'd1, 2'd1};
            4'h6: p = {2'd1, 2'd2};
            4'hB: p = {2'd1, 2'd3};
            4'h7: p = {2'd2, 2'd0};
            4'h8: p = {2'd2, 2'd1};
            4'h9: p = {2'd2, 2'd2};
            4'hC: p = {2'd2, 2'd3};
            4'hE: p = {2'd3, 2'd0};
            4'h0: p = {2'd3, 2'd1};
            4'hF: p = {2'd3, 2'd2};
            default: p = {2'd3, 2'd3};
        endcase
        return p;
    endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// Request handshake between a press requester (master) and the keypad emulator (slave).
interface keypad_emulator_if #(
    parameter int HOLD_W = 16
);
    logic              start;
    logic [3:0]        key;
    logic [HOLD_W-1:0] hold_cycles;
    logic              bounce_en;
    logic              busy;
    logic              done;

    modport master (output start, key, hold_cycles, bounce_en, input busy, done);
    modport slave  (input start, key, hold_cycles, bounce_en, output busy, done);
endinterface

// File: rtl/keypad_emulator_bounce_timer.sv
// Contact-bounce pacing: emits a toggle tick every PERIOD cycles, TOGGLES times after start.
module bounce_timer #(
    parameter int PERIOD  = 50,
    parameter int TOGGLES = 6
) (
    input  logic CLOCK_50,
    input  logic Reset,
    input  logic start,
    output logic tick,
    output logic expired
);
    localparam int PW = (PERIOD  > 1) ? $clog2(PERIOD)  : 1;
    localparam int TW = (TOGGLES > 1) ? $clog2(TOGGLES) : 1;
    localparam logic [PW-1:0] P_LOAD = PW'(PERIOD - 1);
    localparam logic [TW-1:0] T_LOAD = TW'(TOGGLES - 1);

    logic          active;
    logic [PW-1:0] pcnt;
    logic [TW-1:0] tcnt;

    always_ff @(posedge CLOCK_50) begin
        if (!Reset) begin
            active <= 1'b0;
            pcnt   <= '0;
            tcnt   <= '0;
        end else if (start) begin
            active <= 1'b1;
            pcnt   <= P_LOAD;
            tcnt   <= T_LOAD;
        end else if (active) begin
            if (pcnt == '0) begin
                pcnt <= P_LOAD;
                if (tcnt == '0) active <= 1'b0;
                else            tcnt   <= tcnt - 1'b1;
            end else begin
                pcnt <= pcnt - 1'b1;
            end
        end
    end

    assign tick    = active && (pcnt == '0);
    assign expired = tick && (tcnt == '0);
endmodule

// File: rtl/keypad_emulator.sv
// Keypad responder: pulls the selected key's row low while its column is scanned and the contact is closed.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int HOLD_W         = 16,
    parameter int BOUNCE_PERIOD  = 50,
    parameter int BOUNCE_TOGGLES = 6,
    parameter int GAP_CYCLES     = 1000
) (
    input  logic                CLOCK_50,
    input  logic                Reset,
    input  logic [3:0]          cols,
    output logic [3:0]          rows,
    keypad_emulator_if.slave    kp,
    output logic                contact
);
    localparam int GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int CNT_W = (HOLD_W > GW) ? HOLD_W : GW;
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

    state_t            state;
    logic [3:0]        key_q;
    logic [HOLD_W-1:0] hold_q;
    logic              ben_q;
    logic [CNT_W-1:0]  cnt;
    logic              busy_q;
    logic              done_q;
    logic              bt_start;
    logic              bt_tick;
    logic              bt_expired;
    key_pos_t          pos;

    function automatic logic [CNT_W-1:0] hold_load(input logic [HOLD_W-1:0] h);
        return (h == '0) ? '0 : CNT_W'(h - 1'b1);
    endfunction

    // Timer is loaded on the same edge a bounce state is entered so its first tick lands PERIOD cycles later.
    assign bt_start = ((state == S_IDLE) && kp.start && kp.bounce_en) ||
                      ((state == S_HOLD) && (cnt == '0) && ben_q);

    bounce_timer #(
        .PERIOD  (BOUNCE_PERIOD),
        .TOGGLES (BOUNCE_TOGGLES)
    ) u_bounce (
        .CLOCK_50 (CLOCK_50),
        .Reset    (Reset),
        .start    (bt_start),
        .tick     (bt_tick),
        .expired  (bt_expired)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!Reset) begin
            state   <= S_IDLE;
            contact <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt     <= '0;
            key_q   <= '0;
            hold_q  <= '0;
            ben_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: if (kp.start) begin
                    key_q   <= kp.key;
                    hold_q  <= kp.hold_cycles;
                    ben_q   <= kp.bounce_en;
                    busy_q  <= 1'b1;
                    contact <= 1'b1;
                    if (kp.bounce_en) begin
                        state <= S_BOUNCE_IN;
                    end else begin
                        state <= S_HOLD;
                        cnt   <= hold_load(kp.hold_cycles);
                    end
                end
                S_BOUNCE_IN: if (bt_tick) begin
                    contact <= ~contact;
                    if (bt_expired) begin
                        state <= S_HOLD;
                        cnt   <= hold_load(hold_q);
                    end
                end
                S_HOLD: if (cnt == '0) begin
                    contact <= 1'b0;
                    if (ben_q) begin
                        state <= S_BOUNCE_OUT;
                    end else begin
                        state <= S_GAP;
                        cnt   <= GAP_LOAD;
                    end
                end else begin
                    cnt <= cnt - 1'b1;
                end
                S_BOUNCE_OUT: if (bt_tick) begin
                    contact <= ~contact;
                    if (bt_expired) begin
                        state <= S_GAP;
                        cnt   <= GAP_LOAD;
                    end
                end
                S_GAP: if (cnt == '0) begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign kp.busy = busy_q;
    assign kp.done = done_q;
    assign pos     = key_pos(key_q);

    // ~index maps row/col index r to bit 3-r of the active-low buses.
    always_comb begin
        rows = ROW_IDLE;
        if (contact && (cols[~pos.col] == 1'b0))
            rows[~pos.row] = 1'b0;
    end
endmodule

// File: tb/tb_keypad_emulator.sv
// Randomized check of keypad_emulator against a per-cycle contact trace built from the press rules.
module tb_keypad_emulator;
    import keypad_pkg::*;

    localparam int HW = 8;
    localparam int BP = 2;
    localparam int BT = 4;
    localparam int GC = 10;

    logic       CLOCK_50 = 1'b0;
    logic       Reset    = 1'b0;
    logic [3:0] cols     = COL_IDLE;
    logic [3:0] rows;
    logic       contact;

    keypad_emulator_if #(.HOLD_W(HW)) kif ();

    keypad_emulator #(
        .HOLD_W         (HW),
        .BOUNCE_PERIOD  (BP),
        .BOUNCE_TOGGLES (BT),
        .GAP_CYCLES     (GC)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .Reset    (Reset),
        .cols     (cols),
        .rows     (rows),
        .kp       (kif.slave),
        .contact  (contact)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int errors = 0;

    // Keypad face as printed: kmap[r][c].
    logic [3:0] kmap [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                                '{4'h4, 4'h5, 4'h6, 4'hB},
                                '{4'h7, 4'h8, 4'h9, 4'hC},
                                '{4'hE, 4'h0, 4'hF, 4'hD}};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_rows(input logic [3:0] k, input logic [3:0] c, input logic ct);
        logic [3:0] r = 4'b1111;
        if (ct)
            for (int ri = 0; ri < 4; ri++)
                for (int ci = 0; ci < 4; ci++)
                    if (kmap[ri][ci] == k && c[3-ci] == 1'b0) r[3-ri] = 1'b0;
        return r;
    endfunction

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic press(input logic [3:0] k, input int hold, input bit ben, input bit spam,
                         input logic [3:0] cfix, input bit crand);
        bit q[$];
        int h;
        h = (hold == 0) ? 1 : hold;
        if (ben) for (int i = 0; i < BT*BP; i++) q.push_back(((i / BP) % 2) == 0);
        for (int i = 0; i < h; i++) q.push_back(1'b1);
        if (ben) for (int i = 0; i < BT*BP; i++) q.push_back(((i / BP) % 2) == 1);
        for (int i = 0; i < GC; i++) q.push_back(1'b0);

        kif.key = k;
        kif.hold_cycles = HW'(hold);
        kif.bounce_en = ben;
        kif.start = 1'b1;
        cols = crand ? 4'($urandom_range(0, 15)) : cfix;
        tick();
        if (!spam) kif.start = 1'b0;
        foreach (q[i]) begin
            kif.key = 4'($urandom);
            kif.hold_cycles = HW'($urandom);
            kif.bounce_en = 1'($urandom);
            cols = crand ? 4'($urandom_range(0, 15)) : cfix;
            #1;
            check("contact", 32'(contact), 32'(q[i]));
            check("rows", 32'(rows), 32'(exp_rows(k, cols, q[i])));
            check("busy", 32'(kif.busy), 32'd1);
            check("done_early", 32'(kif.done), 32'd0);
            tick();
        end
        check("done", 32'(kif.done), 32'd1);
        check("busy_end", 32'(kif.busy), 32'd0);
        check("rows_end", 32'(rows), 32'hF);
        kif.start = 1'b0;
        tick();
        check("done_width", 32'(kif.done), 32'd0);
        check("no_restart", 32'(kif.busy), 32'd0);
    endtask

    initial begin
        kif.start = 1'b0;
        kif.key = '0;
        kif.hold_cycles = '0;
        kif.bounce_en = 1'b0;
        repeat (3) tick();
        check("rst_rows", 32'(rows), 32'hF);
        check("rst_busy", 32'(kif.busy), 32'd0);
        check("rst_done", 32'(kif.done), 32'd0);
        check("rst_contact", 32'(contact), 32'd0);
        Reset = 1'b1;
        tick();

        // Reset during HOLD aborts without a done pulse.
        kif.key = 4'h5; kif.hold_cycles = HW'(50); kif.bounce_en = 1'b0; kif.start = 1'b1;
        cols = 4'b1011;
        tick();
        kif.start = 1'b0;
        repeat (5) tick();
        check("pre_rst_rows", 32'(rows), 32'hB);
        Reset = 1'b0;
        repeat (3) begin
            tick();
            check("mid_rst_rows", 32'(rows), 32'hF);
            check("mid_rst_busy", 32'(kif.busy), 32'd0);
            check("mid_rst_done", 32'(kif.done), 32'd0);
        end
        Reset = 1'b1;
        repeat (GC + 60) begin
            tick();
            check("post_rst_done", 32'(kif.done), 32'd0);
            check("post_rst_busy", 32'(kif.busy), 32'd0);
        end

        press(4'h5, 20, 1'b0, 1'b0, 4'b1011, 1'b0);
        press(4'h5, 20, 1'b0, 1'b0, 4'b0111, 1'b0);
        press(4'hE, 6, 1'b1, 1'b0, 4'b0111, 1'b0);
        press(4'h3, 5, 1'b0, 1'b1, 4'b1101, 1'b0);
        press(4'hD, 0, 1'b1, 1'b0, 4'b1110, 1'b0);
        press(4'h0, 1, 1'b0, 1'b0, 4'b1011, 1'b0);
        for (int n = 0; n < 10; n++)
            press(4'($urandom), $urandom_range(0, 12), 1'($urandom), 1'($urandom), 4'h0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
